// File: rtl/carry_select_cell.sv
// Carry-select cell: both carry-in hypotheses are precomputed and the real
// carry-in only drives the final mux, keeping it off the ripple path.
module carry_select_cell #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH-1:0] sum_c0;
  logic [WIDTH-1:0] sum_c1;
  logic             cout_c0;
  logic             cout_c1;

  ripple_carry_adder #(.WIDTH(WIDTH)) u_rca_c0 (
    .a    (a),
    .b    (b),
    .cin  (1'b0),
    .sum  (sum_c0),
    .cout (cout_c0)
  );

  ripple_carry_adder #(.WIDTH(WIDTH)) u_rca_c1 (
    .a    (a),
    .b    (b),
    .cin  (1'b1),
    .sum  (sum_c1),
    .cout (cout_c1)
  );

  assign sum  = cin ? sum_c1  : sum_c0;
  assign cout = cin ? cout_c1 : cout_c0;

endmodule

// File: rtl/pipe_valid_reg.sv
// Pipeline stage register: payload plus valid bit, loaded together on
// load, both cleared asynchronously by rst_n.
module pipe_valid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             valid_next,
  input  logic [WIDTH-1:0] data_next,
  output logic             valid_reg,
  output logic [WIDTH-1:0] data_reg
);

  // Capture valid and payload together; payload loads even when invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= valid_next;
      data_reg  <= data_next;
    end
  end

endmodule

// File: rtl/ripple_carry_adder.sv
// Ripple-carry adder: a chain of full-adder cells, LSB first.
module ripple_carry_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/pipelined_carry_select_subtractor.sv
// Two-stage subtractor diff = a - b - borrow_in, computed as a + ~b + ~borrow_in.
// Stage 1 ripples the low half; stage 2 finishes the high half with a
// carry-select cell driven by the registered low-half carry.
module pipelined_carry_select_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int HALF = WIDTH / 2;
  // Stage 1 payload: low diff, low carry, a_hi, ~b_hi, a msb, b msb.
  localparam int S1_W = 3 * HALF + 3;
  // Stage 2 payload: diff, borrow_out, overflow.
  localparam int S2_W = WIDTH + 2;

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_width_check
    $error("pipelined_carry_select_subtractor: WIDTH must be even and >= 2");
  end

  // Handshake: a stage may load when it is empty or its content moves on.
  logic s1_valid;
  logic s2_ready;

  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;

  // Stage 1: low half via ripple chain on inverted subtrahend.
  logic [HALF-1:0] lo_diff;
  logic            lo_carry;
  logic [HALF-1:0] b_lo_inv;
  logic [S1_W-1:0] s1_next;
  logic [S1_W-1:0] s1_reg;

  assign b_lo_inv = ~b[HALF-1:0];

  ripple_carry_adder #(.WIDTH(HALF)) u_lo (
    .a    (a[HALF-1:0]),
    .b    (b_lo_inv),
    .cin  (~borrow_in),
    .sum  (lo_diff),
    .cout (lo_carry)
  );

  assign s1_next = {lo_diff, lo_carry, a[WIDTH-1:HALF], ~b[WIDTH-1:HALF],
                    a[WIDTH-1], b[WIDTH-1]};

  pipe_valid_reg #(.WIDTH(S1_W)) u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (in_ready),
    .valid_next (in_valid),
    .data_next  (s1_next),
    .valid_reg  (s1_valid),
    .data_reg   (s1_reg)
  );

  logic [HALF-1:0] s1_lo_diff;
  logic            s1_lo_carry;
  logic [HALF-1:0] s1_a_hi;
  logic [HALF-1:0] s1_nb_hi;
  logic            s1_a_msb;
  logic            s1_b_msb;

  assign {s1_lo_diff, s1_lo_carry, s1_a_hi, s1_nb_hi, s1_a_msb, s1_b_msb} = s1_reg;

  // Stage 2: high half via carry-select, selected by the registered low carry.
  logic [HALF-1:0] hi_diff;
  logic            hi_carry;
  logic            borrow_next;
  logic            overflow_next;
  logic [S2_W-1:0] s2_next;
  logic [S2_W-1:0] s2_reg;

  carry_select_cell #(.WIDTH(HALF)) u_hi (
    .a    (s1_a_hi),
    .b    (s1_nb_hi),
    .cin  (s1_lo_carry),
    .sum  (hi_diff),
    .cout (hi_carry)
  );

  // No carry out of the MSB means the subtraction borrowed.
  assign borrow_next   = ~hi_carry;
  // Signed overflow: operand signs differ and the result sign left a's sign.
  assign overflow_next = (s1_a_msb != s1_b_msb) && (hi_diff[HALF-1] != s1_a_msb);
  assign s2_next       = {hi_diff, s1_lo_diff, borrow_next, overflow_next};

  pipe_valid_reg #(.WIDTH(S2_W)) u_s2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (s2_ready),
    .valid_next (s1_valid),
    .data_next  (s2_next),
    .valid_reg  (out_valid),
    .data_reg   (s2_reg)
  );

  assign {diff, borrow_out, overflow} = s2_reg;

endmodule

// File: tb/tb_pipelined_carry_select_subtractor.sv
// Directed-vector bench for the pipelined subtractor at WIDTH=8.
module tb_pipelined_carry_select_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       borrow_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       borrow_out;
  logic       overflow;

  int nvec;
  int nmis;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } vec_t;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    logic       ovf;
  } res_t;

  vec_t vecs[8];
  res_t exp_q[$];

  pipelined_carry_select_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t ref_sub(input logic [7:0] x, input logic [7:0] y, input logic bi);
    res_t r;
    logic [8:0] full;
    full   = {1'b0, x} - {1'b0, y} - {8'b0, bi};
    r.diff = full[7:0];
    r.bout = full[8];
    r.ovf  = (x[7] != y[7]) && (full[7] != x[7]);
    return r;
  endfunction

  // Single transaction through an empty pipeline, checking latency and result.
  task automatic apply_vec(input int i);
    int lat;
    @(negedge clk);
    a = vecs[i].a; b = vecs[i].b; borrow_in = vecs[i].bin;
    in_valid = 1'b1; out_ready = 1'b1;
    chk("vec_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("vec_latency", 32'(lat), 32'd2);
    chk("vec_diff", 32'(diff), 32'(vecs[i].diff));
    chk("vec_borrow", 32'(borrow_out), 32'(vecs[i].bout));
    chk("vec_overflow", 32'(overflow), 32'(vecs[i].ovf));
    $display("vec %0d: %02h - %02h - %0d -> diff=%02h borrow=%0d ovf=%0d", i,
             vecs[i].a, vecs[i].b, vecs[i].bin, diff, borrow_out, overflow);
  endtask

  task automatic check_out(input string name, input logic v, input logic [7:0] d, input logic ir);
    chk({name, "_out_valid"}, 32'(out_valid), 32'(v));
    if (v) chk({name, "_diff"}, 32'(diff), 32'(d));
    chk({name, "_in_ready"}, 32'(in_ready), 32'(ir));
  endtask

  initial begin
    int nres;
    int cyc;
    res_t r;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rbi;

    nvec = 0;
    nmis = 0;

    vecs[0] = '{8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'h00; b = 8'h00; borrow_in = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) apply_vec(i);

    // Backpressure: hold the output for four cycles with three inputs offered.
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    a = 8'h05; b = 8'h01; borrow_in = 1'b0; in_valid = 1'b1;
    check_out("bp0", 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    a = 8'h09; b = 8'h02;
    check_out("bp1", 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    a = 8'h0C; b = 8'h03;
    check_out("bp2", 1'b1, 8'h04, 1'b0);
    @(negedge clk);
    check_out("bp3", 1'b1, 8'h04, 1'b0);
    @(negedge clk);
    check_out("bp4", 1'b1, 8'h04, 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_comb", 32'(in_ready), 32'd1);
    $display("backpressure: held diff=%02h while stalled", diff);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("bp5", 1'b1, 8'h07, 1'b1);
    $display("backpressure: drained diff=%02h", diff);
    @(negedge clk);
    check_out("bp6", 1'b1, 8'h09, 1'b1);
    $display("backpressure: drained diff=%02h", diff);
    @(negedge clk);
    chk("bp7_out_valid", 32'(out_valid), 32'd0);

    // Full throughput: 16 back-to-back random operand sets.
    nres = 0;
    cyc = 0;
    exp_q.delete();
    while ((nres < 16) && (cyc < 40)) begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("tp_unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          r = exp_q.pop_front();
          chk("tp_diff", 32'(diff), 32'(r.diff));
          chk("tp_borrow", 32'(borrow_out), 32'(r.bout));
          chk("tp_overflow", 32'(overflow), 32'(r.ovf));
          $display("stream result %0d: diff=%02h borrow=%0d ovf=%0d", nres, diff, borrow_out, overflow);
        end
        nres++;
      end
      if (cyc < 16) begin
        chk("tp_in_ready", 32'(in_ready), 32'd1);
        ra = 8'($urandom); rb = 8'($urandom); rbi = 1'($urandom);
        a = ra; b = rb; borrow_in = rbi; in_valid = 1'b1;
        exp_q.push_back(ref_sub(ra, rb, rbi));
      end else begin
        in_valid = 1'b0;
      end
      cyc++;
    end
    chk("tp_result_count", 32'(nres), 32'd16);
    chk("tp_cycles", 32'(cyc), 32'd18);

    // Reset mid-operation with two results in flight.
    @(negedge clk);
    out_ready = 1'b1;
    a = 8'h33; b = 8'h11; borrow_in = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 8'h44; b = 8'h22;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("mr_pre_out_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_diff", 32'(diff), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd1);
    #1 rst_n = 1'b1;
    $display("mid-stream reset applied");
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mr_no_stale", 32'(out_valid), 32'd0);
      chk("mr_in_ready_after", 32'(in_ready), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/pipelined_carry_select_subtractor.md
Name: pipelined_carry_select_subtractor

Overview:
Two-stage pipelined subtractor computing diff = a - b - borrow_in. It is the subtraction counterpart of the combinational carry-select adder.
- Stage 1 resolves the low half with a ripple cell.
- Stage 2 resolves the high half with a carry-select cell.
- Valid/ready handshakes on input and output allow the block to sit inside streaming arithmetic datapaths with backpressure.

Parameters:
WIDTH, 8, operand/result width in bits; must be even and >= 2; odd values raise $error at elaboration.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set on a/b/borrow_in is valid
in_ready  output  1  block accepts an operand set this cycle
a  input  WIDTH  minuend (unsigned, or two's complement for overflow)
b  input  WIDTH  subtrahend
borrow_in  input  1  borrow into bit 0
out_valid  output  1  diff/borrow_out/overflow hold a valid result
out_ready  input  1  downstream accepts the result this cycle
diff  output  WIDTH  a - b - borrow_in, mod 2^WIDTH
borrow_out  output  1  1 when unsigned a < b + borrow_in
overflow  output  1  signed two's-complement overflow of the subtraction

Behaviour:
- Interface: one clock, clk; reset asynchronous, active-low, rst_n.
- Arithmetic: a - b - bin = a + ~b + ~bin.
  - Internal carry chain is fed ~b and carry_in = ~borrow_in.
  - borrow_out = ~carry_out of the MSB.
  - overflow = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]).
- Stage 1 register captures:
  - low-half difference (WIDTH/2 bits)
  - low-half carry
  - a[W-1:W/2] and ~b[W-1:W/2]
  - a[W-1] and b[W-1] for the overflow calculation
  - s1_valid
- Stage 2 register:
  - Carry-select cell on the registered high operands, selected by the registered low carry.
  - Captures full diff, borrow_out, overflow and out_valid.
- Latency: exactly 2 cycles from the accepting edge (in_valid && in_ready) to out_valid, with no stalls.
- Throughput: 1 result/cycle while out_ready stays high.
- Handshake rules:
  - s2_ready = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_ready.
  - in_ready is combinational from out_ready.
  - Stage 1 advances into stage 2 when s1_valid && s2_ready.
  - Stage 2 register loads on s2_ready, taking s1_valid as the new out_valid.
  - Stage 1 loads on in_ready, taking in_valid as the new s1_valid.
- Output stability:
  - While out_valid && !out_ready, diff/borrow_out/overflow/out_valid hold unchanged.
  - Stage 1 holds too when full.
  - At most 2 results are in flight; none is dropped or duplicated; order is preserved.
- Simultaneous events: a full pipeline with out_ready=1 and in_valid=1 accepts a new input and emits a result in the same cycle.
- Data while invalid: payload registers load even when the valid bit is 0 (don't-care data). Only the valid bits are checked.
- Reset:
  - Asserting rst_n low at any time, including mid-stream, clears s1_valid and out_valid immediately (asynchronously).
  - diff, borrow_out and overflow reset to 0.
  - In-flight results are discarded.
  - After deassertion, in_ready = 1 on the first cycle.

Decomposition:
- No shared package; the only constant is WIDTH/2, computed locally as localparam HALF.
- Reuse existing ripple_carry_adder #(HALF) for stage 1 and carry_select_cell #(HALF) for stage 2, fed inverted b and inverted borrow.
- One natural sub-module: pipe_valid_reg, a WIDTH-parameterised data+valid register with load enable and async active-low clear, instantiated once per stage.

Test Plan:
- WIDTH=8, a=0x50, b=0x20, bin=0, out_ready=1 -> 2 cycles later diff=0x30, borrow_out=0, overflow=0.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, borrow_out=1, overflow=0; then a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1.
- Cross-half borrow: a=0x10, b=0x01, bin=1 -> diff=0x0E, borrow_out=0; a=0x00, b=0x00, bin=1 -> diff=0xFF, borrow_out=1.
- Backpressure: stream inputs 0x05-0x01, 0x09-0x02, 0x0C-0x03 with out_ready=0 for 4 cycles:
  - out_valid rises with 0x04 held stable; in_ready=0 after 2 accepts.
  - Release out_ready -> outputs 0x04, 0x07, 0x09 in order, no loss.
- Full-throughput: 16 back-to-back random operand sets, out_ready=1 -> 16 consecutive results matching the reference model, in_ready constantly 1.
- Reset mid-operation: 2 results in flight, pulse rst_n low between edges -> out_valid=0 and diff=0 immediately; no stale result appears after release.
